// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
//   Multi-digit BCD up/down counter with a display-scan multiplexer that
//   feeds a BCD-to-7-segment decoder.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         count enable, one step per cycle
//   up         1 = increment, 0 = decrement
//   load       synchronous load of load_val (digits 10..15 clamp to 9)
//   load_val   BCD value to load, digit 0 in bits [3:0]
//   count      registered BCD count
//   carry      one-cycle pulse on wrap in either direction
//   bcd_out    digit currently being scanned
//   digit_sel  one-hot select of the scanned digit
//   blank      scanned digit is a suppressed leading zero
module bcd_scan_counter #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic [3:0]            bcd_out,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  blank
);

   localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [IDX_W-1:0]    scan_idx;
   logic [DIV_W-1:0]    scan_div;

   logic [4*DIGITS-1:0] inc_val;
   logic [4*DIGITS-1:0] dec_val;
   logic [4*DIGITS-1:0] load_clamped;
   logic                inc_wrap;
   logic                dec_wrap;

   logic [DIGITS-1:0]   lz;
   logic                zero_above;

   // Ripple chains: the carry/borrow flag survives the loop only if every
   // digit rolled over, which is exactly the wrap condition.
   always_comb begin
      inc_val      = count;
      dec_val      = count;
      load_clamped = load_val;
      inc_wrap     = 1'b1;
      dec_wrap     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (inc_wrap) begin
            if (count[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
               inc_wrap          = 1'b0;
            end
         end
         if (dec_wrap) begin
            if (count[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
               dec_wrap          = 1'b0;
            end
         end
         if (load_val[4*i +: 4] > 4'd9) begin
            load_clamped[4*i +: 4] = 4'd9;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         carry <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         carry <= 1'b0;
      end else if (en) begin
         count <= up ? inc_val  : dec_val;
         carry <= up ? inc_wrap : dec_wrap;
      end else begin
         carry <= 1'b0;
      end
   end

   // Scan timing runs free of en/load so the display never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_div <= '0;
         scan_idx <= '0;
      end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
         scan_div <= '0;
         if (scan_idx == IDX_W'(DIGITS - 1)) begin
            scan_idx <= '0;
         end else begin
            scan_idx <= scan_idx + IDX_W'(1);
         end
      end else begin
         scan_div <= scan_div + DIV_W'(1);
      end
   end

   // lz[i]: digit i and every digit above it are zero.
   always_comb begin
      lz         = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lz[i]      = zero_above && (count[4*i +: 4] == 4'd0);
         zero_above = lz[i];
      end
   end

   always_comb begin
      bcd_out   = 4'd0;
      digit_sel = '0;
      blank     = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            bcd_out      = count[4*i +: 4];
            digit_sel[i] = 1'b1;
            if ((i > 0) && (BLANK_LZ != 0)) begin
               blank = lz[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int BLANK_LZ = 1;
   localparam int MODULUS  = 10000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en = 1'b0;
   logic                up = 1'b0;
   logic                load = 1'b0;
   logic [4*DIGITS-1:0] load_val = '0;
   logic [4*DIGITS-1:0] count;
   logic                carry;
   logic [3:0]          bcd_out;
   logic [DIGITS-1:0]   digit_sel;
   logic                blank;

   bcd_scan_counter #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .BLANK_LZ (BLANK_LZ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .count     (count),
      .carry     (carry),
      .bcd_out   (bcd_out),
      .digit_sel (digit_sel),
      .blank     (blank)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model: count as a plain decimal integer, scan position as
   // cycles elapsed since reset.
   int m_val   = 0;
   int m_carry = 0;
   int n_cyc   = 0;
   int m_wraps = 0;
   int d_wraps = 0;

   typedef struct {
      logic        rst;
      logic        load;
      logic        en;
      logic        up;
      logic [15:0] load_val;
      logic [15:0] exp_count;
      logic        exp_carry;
      string       name;
   } vec_t;

   vec_t vecs[15];

   function automatic int clamp_to_int(input logic [15:0] v);
      int r = 0;
      int p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         int d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r += d * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t /= 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n_cyc);
      end
   endtask

   task automatic tick();
      m_carry = 0;
      if (rst) begin
         m_val = 0;
         n_cyc = 0;
      end else begin
         n_cyc++;
         if (load) begin
            m_val = clamp_to_int(load_val);
         end else if (en) begin
            if (up) begin
               if (m_val == MODULUS - 1) begin m_val = 0; m_carry = 1; end
               else m_val++;
            end else begin
               if (m_val == 0) begin m_val = MODULUS - 1; m_carry = 1; end
               else m_val--;
            end
         end
      end
      if (m_carry != 0) m_wraps++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_scan(input string tag);
      int idx = (n_cyc / SCAN_DIV) % DIGITS;
      int p   = 10 ** idx;
      check({tag, "_sel"},   32'(digit_sel), 32'(1 << idx));
      check({tag, "_bcd"},   32'(bcd_out),   32'((m_val / p) % 10));
      check({tag, "_blank"}, 32'(blank),     32'((idx > 0 && m_val < p) ? 1 : 0));
   endtask

   initial begin
      logic [3:0] scan_bcd [4];
      int         pick;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "reset"};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h9998, 16'h9998, 1'b0, "load_9998"};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b0, "inc_9999"};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, "inc_wrap"};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, "inc_0001"};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, "load_0001"};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "dec_0000"};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1, "dec_wrap"};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0, "dec_9998"};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1A3F, 16'h1939, 1'b0, "load_clamp"};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0005, 1'b0, "load_over_en"};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0005, 1'b0, "hold"};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0041, 1'b0, "load_0041"};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0042, 1'b0, "inc_0042"};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0999, 16'h0000, 1'b0, "reset_prio"};

      for (int v = 0; v < 15; v++) begin
         rst      = vecs[v].rst;
         load     = vecs[v].load;
         en       = vecs[v].en;
         up       = vecs[v].up;
         load_val = vecs[v].load_val;
         tick();
         check({vecs[v].name, "_count"}, 32'(count), 32'(vecs[v].exp_count));
         check({vecs[v].name, "_carry"}, 32'(carry), 32'(vecs[v].exp_carry));
      end
      // Reset landed while the scan sat on digit 3.
      check("rst_sel",   32'(digit_sel), 32'h1);
      check("rst_bcd",   32'(bcd_out),   32'h0);
      check("rst_blank", 32'(blank),     32'h0);

      // Scan sequence over 0307: realign to a fresh reset, load, idle to n=16.
      rst = 1'b1; load = 1'b0; en = 1'b0;
      tick();
      rst = 1'b0; load = 1'b1; load_val = 16'h0307;
      tick();
      load = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      scan_bcd[0] = 4'd7; scan_bcd[1] = 4'd0; scan_bcd[2] = 4'd3; scan_bcd[3] = 4'd0;
      for (int k = 0; k < 16; k++) begin
         check("scan_sel",   32'(digit_sel), 32'(1 << (k / 4)));
         check("scan_bcd",   32'(bcd_out),   32'(scan_bcd[k / 4]));
         check("scan_blank", 32'(blank),     32'((k / 4 == 3) ? 1 : 0));
         tick();
      end

      // Random run against the decimal model.
      rst = 1'b1; load = 1'b0; en = 1'b0;
      tick();
      check("rand_reset", 32'(count), 32'h0);
      rst = 1'b0;
      m_wraps = 0;
      d_wraps = 0;
      for (int c = 0; c < 2000; c++) begin
         en   = 1'($urandom_range(0, 1));
         up   = 1'($urandom_range(0, 1));
         load = ($urandom_range(0, 63) == 0);
         pick = $urandom_range(0, 3);
         case (pick)
            0:       load_val = 16'h9997;
            1:       load_val = 16'h0002;
            default: load_val = 16'($urandom);
         endcase
         tick();
         if (carry) d_wraps++;
         check("rand_count", 32'(count), 32'(to_bcd(m_val)));
         check("rand_carry", 32'(carry), 32'(m_carry));
         check_scan("rand");
      end
      check("wrap_total", 32'(d_wraps), 32'(m_wraps));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
